// File: rtl/lib_accum_pkg.sv
// -----------------------------------------------------------------------------
// lib_accum_pkg
// Shared types and default constants for the block accumulator.
//   state_e        : FSM state (ACCUM collecting samples, HOLD presenting sum)
//   LIB_DATA_W     : default sample / result width
//   LIB_ACC_W      : default internal accumulator width (>= DATA_W + 8)
//   LIB_BLOCK_LEN  : default samples per block (1..255)
//   CNT_W          : sample counter width, wide enough for BLOCK_LEN <= 255
// -----------------------------------------------------------------------------
package lib_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int unsigned LIB_DATA_W    = 32;
  localparam int unsigned LIB_ACC_W     = 40;
  localparam int unsigned LIB_BLOCK_LEN = 8;
  localparam int unsigned CNT_W         = 8;

endpackage : lib_accum_pkg

// File: rtl/lib_accum_narrow.sv
// -----------------------------------------------------------------------------
// lib_accum_narrow
// Purely combinational ACC_W -> DATA_W narrowing of a final block sum.
//   Build option LIB_ACCUM_SATURATE_EN:
//     defined   : sums above 2^DATA_W-1 clamp to all ones
//     undefined : low DATA_W bits are kept (modulo wrap)
// Ports:
//   sum_i    in  ACC_W   full-precision block sum
//   narrow_o out DATA_W  narrowed result
// -----------------------------------------------------------------------------
module lib_accum_narrow #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  sum_i,
  output logic [DATA_W-1:0] narrow_o
);

`ifdef LIB_ACCUM_SATURATE_EN
  // Any set bit above the result width means the sum does not fit.
  assign narrow_o = (|sum_i[ACC_W-1:DATA_W]) ? '1 : sum_i[DATA_W-1:0];
`else
  logic unused_hi;

  assign narrow_o  = sum_i[DATA_W-1:0];
  assign unused_hi = ^sum_i[ACC_W-1:DATA_W];
`endif

endmodule : lib_accum_narrow

// File: rtl/lib_accum_rtl.sv
// -----------------------------------------------------------------------------
// lib_accum_rtl
// Block accumulator: sums BLOCK_LEN unsigned samples (or fewer, when a sample
// arrives with ilast) and presents the narrowed sum with a valid/ready
// handshake. Narrowing behaviour depends on the build option
// LIB_ACCUM_SATURATE_EN (see lib_accum_narrow).
// Parameters:
//   DATA_W    sample / result width
//   ACC_W     accumulator width, must be >= DATA_W + 8 so 255 samples never wrap
//   BLOCK_LEN samples per block, 1..255
// Ports:
//   clock    in   1       rising-edge clock
//   reset    in   1       synchronous active-high reset
//   ivalid   in   1       sample valid
//   datain   in   DATA_W  sample
//   ilast    in   1       sample closes a short block
//   iready   in   1       downstream takes the result
//   oready   out  1       a sample can be accepted this cycle
//   ovalid   out  1       dataout holds a completed block sum
//   dataout  out  DATA_W  block sum
// -----------------------------------------------------------------------------
module lib_accum_rtl
  import lib_accum_pkg::*;
#(
  parameter int unsigned DATA_W    = LIB_DATA_W,
  parameter int unsigned ACC_W     = LIB_ACC_W,
  parameter int unsigned BLOCK_LEN = LIB_BLOCK_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ivalid,
  input  logic [DATA_W-1:0] datain,
  input  logic              ilast,
  input  logic              iready,
  output logic              oready,
  output logic              ovalid,
  output logic [DATA_W-1:0] dataout
);

  localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

  state_e            state_q;
  logic              ovalid_q;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              accept;
  logic              close;

  // In HOLD, oready follows iready, so an accepted sample in HOLD always
  // coincides with the result being consumed.
  assign oready  = ~reset & ((state_q == ACCUM) | iready);
  assign ovalid  = ~reset & ovalid_q;
  assign dataout = reset ? '0 : result_q;
  assign accept  = ivalid & oready;

  // acc_q/cnt_q are cleared whenever a block closes, so while in HOLD they
  // are zero and the same "add to running sum" path starts the next block.
  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    acc_d = acc_q + {{(ACC_W-DATA_W){1'b0}}, datain};
    cnt_d = cnt_q + CNT_W'(1);
    close = (cnt_d == BLOCK_LEN_C) | ilast;
  end

  lib_accum_narrow #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_narrow (
    .sum_i    (acc_d),
    .narrow_o (result_d)
  );

  // NOTE: clocked state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ACCUM;
      ovalid_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      if (close) begin
        result_q <= result_d;
        acc_q    <= '0;
        cnt_q    <= '0;
        state_q  <= HOLD;
        ovalid_q <= 1'b1;
      end else begin
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
        state_q  <= ACCUM;
        ovalid_q <= 1'b0;
      end
    end else if ((state_q == HOLD) && iready) begin
      state_q  <= ACCUM;
      ovalid_q <= 1'b0;
    end
  end

endmodule : lib_accum_rtl

// File: tb/tb_lib_accum_rtl.sv
// -----------------------------------------------------------------------------
// tb_lib_accum_rtl
// Two instances: u_a with BLOCK_LEN=8 and u_b with BLOCK_LEN=1, sharing clock
// and reset. A block-level model (running sum, sample count, pending result)
// predicts oready/ovalid/dataout; a negedge process compares both DUTs to it
// every cycle. Directed scenarios pin literal values, then random traffic.
// -----------------------------------------------------------------------------
module tb_lib_accum_rtl;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 40;

  logic              clock = 1'b0;
  logic              reset = 1'b1;

  logic              a_ivalid = 1'b0, a_ilast = 1'b0, a_iready = 1'b0;
  logic [DATA_W-1:0] a_datain = '0;
  logic              a_oready, a_ovalid;
  logic [DATA_W-1:0] a_dataout;

  logic              b_ivalid = 1'b0, b_ilast = 1'b0, b_iready = 1'b0;
  logic [DATA_W-1:0] b_datain = '0;
  logic              b_oready, b_ovalid;
  logic [DATA_W-1:0] b_dataout;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  lib_accum_rtl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BLOCK_LEN(8)) u_a (
    .clock(clock), .reset(reset), .ivalid(a_ivalid), .datain(a_datain),
    .ilast(a_ilast), .iready(a_iready), .oready(a_oready),
    .ovalid(a_ovalid), .dataout(a_dataout)
  );

  lib_accum_rtl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BLOCK_LEN(1)) u_b (
    .clock(clock), .reset(reset), .ivalid(b_ivalid), .datain(b_datain),
    .ilast(b_ilast), .iready(b_iready), .oready(b_oready),
    .ovalid(b_ovalid), .dataout(b_dataout)
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned     m_blen [2] = '{8, 1};
  bit              m_hold [2];
  longint unsigned m_sum  [2];
  int unsigned     m_cnt  [2];
  longint unsigned m_res  [2];

  function automatic longint unsigned narrow(input longint unsigned s);
    longint unsigned max_v = (64'd1 << DATA_W) - 1;
`ifdef LIB_ACCUM_SATURATE_EN
    return (s > max_v) ? max_v : s;
`else
    return s & max_v;
`endif
  endfunction

  function automatic bit m_oready(input int i, input bit rdy);
    return !reset && (!m_hold[i] || rdy);
  endfunction

  task automatic model_edge(input int i, input bit vld, input longint unsigned d,
                            input bit last, input bit rdy);
    longint unsigned s;
    if (reset) begin
      m_hold[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_res[i] = 0;
    end else if (vld && m_oready(i, rdy)) begin
      // A sample taken while holding means the old result left this cycle.
      s = m_sum[i] + d;
      if (m_cnt[i] + 1 == m_blen[i] || last) begin
        m_res[i] = narrow(s); m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 1;
      end else begin
        m_sum[i] = s; m_cnt[i] = m_cnt[i] + 1; m_hold[i] = 0;
      end
    end else if (m_hold[i] && rdy) begin
      m_hold[i] = 0;
    end
  endtask

  always @(posedge clock) begin
    model_edge(0, a_ivalid, 64'(a_datain), a_ilast, a_iready);
    model_edge(1, b_ivalid, 64'(b_datain), b_ilast, b_iready);
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("a_oready", 64'(a_oready), 64'(m_oready(0, a_iready)));
      check("a_ovalid", 64'(a_ovalid), 64'(!reset && m_hold[0]));
      if (reset || m_hold[0]) check("a_dataout", 64'(a_dataout), reset ? 64'd0 : m_res[0]);
      check("b_oready", 64'(b_oready), 64'(m_oready(1, b_iready)));
      check("b_ovalid", 64'(b_ovalid), 64'(!reset && m_hold[1]));
      if (reset || m_hold[1]) check("b_dataout", 64'(b_dataout), reset ? 64'd0 : m_res[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [DATA_W-1:0] d, input logic last);
    a_ivalid = 1'b1; a_datain = d; a_ilast = last;
    step();
    a_ivalid = 1'b0; a_ilast = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    if ($urandom_range(0, 3) == 0) return DATA_W'(32'hFFFF_FFFF - $urandom_range(0, 15));
    return DATA_W'($urandom);
  endfunction

  initial begin
    step();
    cmp_en = 1'b1;
    step();
    // Reset state
    check("rst_oready", 64'(a_oready), 64'd0);
    check("rst_ovalid", 64'(a_ovalid), 64'd0);
    check("rst_dataout", 64'(a_dataout), 64'd0);
    reset = 1'b0;

    // Full block 1..8, downstream ready
    a_iready = 1'b1;
    for (int k = 1; k <= 8; k++) send_a(DATA_W'(k), 1'b0);
    check("blk8_ovalid", 64'(a_ovalid), 64'd1);
    check("blk8_dataout", 64'(a_dataout), 64'd36);
    check("blk8_model", m_res[0], 64'd36);
    step();
    check("blk8_one_cycle", 64'(a_ovalid), 64'd0);

    // Short block 5,6,7 with ilast, downstream stalled
    a_iready = 1'b0;
    send_a(5, 1'b0); send_a(6, 1'b0); send_a(7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("stall_ovalid", 64'(a_ovalid), 64'd1);
      check("stall_dataout", 64'(a_dataout), 64'd18);
      check("stall_oready", 64'(a_oready), 64'd0);
      step();
    end
    a_iready = 1'b1;
    #1;
    check("stall_release_oready", 64'(a_oready), 64'd1);
    step();
    check("stall_consumed", 64'(a_ovalid), 64'd0);

    // Consume and restart in the same cycle
    a_iready = 1'b0;
    for (int k = 1; k <= 8; k++) send_a(DATA_W'(k), 1'b0);
    check("hold36_dataout", 64'(a_dataout), 64'd36);
    a_iready = 1'b1;
    send_a(100, 1'b0);
    check("restart_ovalid", 64'(a_ovalid), 64'd0);
    for (int k = 0; k < 7; k++) send_a(1, 1'b0);
    check("restart_ovalid2", 64'(a_ovalid), 64'd1);
    check("restart_dataout", 64'(a_dataout), 64'd107);
    step();

    // Overflow of the result width
    for (int k = 0; k < 8; k++) send_a(32'hFFFF_FFFF, 1'b0);
`ifdef LIB_ACCUM_SATURATE_EN
    check("ovf_dataout", 64'(a_dataout), 64'hFFFF_FFFF);
`else
    check("ovf_dataout", 64'(a_dataout), 64'hFFFF_FFF8);
`endif
    step();

    // Reset mid-block discards the partial sum
    for (int k = 0; k < 3; k++) send_a(9, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_ovalid", 64'(a_ovalid), 64'd0);
    for (int k = 0; k < 8; k++) send_a(2, 1'b0);
    check("midrst_dataout", 64'(a_dataout), 64'd16);
    step();

    // BLOCK_LEN=1: every sample is a result
    b_iready = 1'b1; b_ivalid = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      b_datain = DATA_W'(k);
      step();
      check("bl1_ovalid", 64'(b_ovalid), 64'd1);
      check("bl1_dataout", 64'(b_dataout), 64'(k));
    end
    b_ivalid = 1'b0;
    step();
    check("bl1_drain", 64'(b_ovalid), 64'd0);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      a_ivalid = ($urandom_range(0, 3) != 0);
      a_datain = rnd_data();
      a_ilast  = ($urandom_range(0, 7) == 0);
      a_iready = ($urandom_range(0, 2) != 0);
      b_ivalid = ($urandom_range(0, 3) != 0);
      b_datain = rnd_data();
      b_ilast  = ($urandom_range(0, 7) == 0);
      b_iready = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 1'b0;
    a_ivalid = 1'b0; b_ivalid = 1'b0;
    step();
    @(negedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_lib_accum_rtl
